// File: rtl/alu_muldiv.sv
// Multi-cycle MIPS execute-stage ALU: single-cycle shift/arith/logic/compare ops plus an
// iterative signed/unsigned multiply and restoring divide that update internal HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [OP_W-1:0]  i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_overflow,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(12);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(16);

  logic [1:0]       state_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_rem_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] result_r;
  logic             valid_r;
  logic             zero_r;
  logic             neg_r;
  logic             ovf_r;
  logic             dbz_r;

  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_zero_s;
  logic             sc_neg_s;
  logic             sc_ovf_s;

  // Single-cycle datapath: result and flags for the opcode presented this cycle
  always_comb begin
    shamt_s   = i_a[SHW-1:0];
    sum_s     = i_a + i_b;
    diff_s    = i_a - i_b;
    sc_res_s  = {WIDTH{1'b0}};
    sc_zero_s = 1'b0;
    sc_neg_s  = 1'b0;
    sc_ovf_s  = 1'b0;
    case (i_opcode)
      OP_SLL:  sc_res_s = i_b << shamt_s;
      OP_SRL:  sc_res_s = i_b >> shamt_s;
      OP_SRA:  sc_res_s = $unsigned($signed(i_b) >>> shamt_s);
      OP_ADD: begin
        sc_res_s = sum_s;
        sc_ovf_s = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum_s[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_s  = diff_s;
        sc_zero_s = (i_a == i_b);
        sc_neg_s  = diff_s[WIDTH-1];
        sc_ovf_s  = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff_s[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND:  sc_res_s = i_a & i_b;
      OP_OR:   sc_res_s = i_a | i_b;
      OP_XOR:  sc_res_s = i_a ^ i_b;
      OP_NOR:  sc_res_s = ~(i_a | i_b);
      OP_SLT:  sc_res_s = ($signed(i_a) < $signed(i_b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
      OP_SLTU: sc_res_s = (i_a < i_b) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
      OP_MFHI: sc_res_s = hi_r;
      OP_MFLO: sc_res_s = lo_r;
      default: sc_res_s = {WIDTH{1'b0}};
    endcase
  end

  logic             is_mul_op_s;
  logic             is_div_op_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;

  // Operand magnitudes and sign bookkeeping captured when a mul/div starts
  always_comb begin
    is_mul_op_s = (i_opcode == OP_MULT) || (i_opcode == OP_MULTU);
    is_div_op_s = (i_opcode == OP_DIV) || (i_opcode == OP_DIVU);
    a_neg_s = ((i_opcode == OP_MULT) || (i_opcode == OP_DIV)) && i_a[WIDTH-1];
    b_neg_s = ((i_opcode == OP_MULT) || (i_opcode == OP_DIV)) && i_b[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = {WIDTH{1'b0}} - i_a;
    end else begin
      a_mag_s = i_a;
    end
    if (b_neg_s) begin
      b_mag_s = {WIDTH{1'b0}} - i_b;
    end else begin
      b_mag_s = i_b;
    end
  end

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic [WIDTH:0]     acc_nx_s;
  logic [WIDTH-1:0]   q_nx_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   hi_nx_s;
  logic [WIDTH-1:0]   lo_nx_s;

  // One iteration step (shift-add multiply / restoring divide) and the final sign fix-up
  always_comb begin
    mul_sum_s   = acc_r + (q_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, m_r};
    if (is_div_r) begin
      if (!div_trial_s[WIDTH]) begin
        acc_nx_s = div_trial_s;
        q_nx_s   = {q_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx_s = div_shift_s;
        q_nx_s   = {q_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx_s = {1'b0, mul_sum_s[WIDTH:1]};
      q_nx_s   = {mul_sum_s[0], q_r[WIDTH-1:1]};
    end
    prod_s     = {acc_r[WIDTH-1:0], q_r};
    prod_fix_s = neg_q_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
    quo_fix_s  = neg_q_r ? ({WIDTH{1'b0}} - q_r) : q_r;
    rem_fix_s  = neg_rem_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    if (is_div_r) begin
      hi_nx_s = rem_fix_s;
      lo_nx_s = quo_fix_s;
    end else begin
      hi_nx_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_nx_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Control FSM, iterative unit state, HI/LO and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= {SHW{1'b0}};
      acc_r     <= {(WIDTH+1){1'b0}};
      q_r       <= {WIDTH{1'b0}};
      m_r       <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      result_r  <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      zero_r    <= 1'b0;
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      dbz_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
      dbz_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_valid) begin
            if (is_div_op_s && (i_b == {WIDTH{1'b0}})) begin
              result_r <= {WIDTH{1'b0}};
              valid_r  <= 1'b1;
              dbz_r    <= 1'b1;
            end else if (is_mul_op_s || is_div_op_s) begin
              state_r   <= S_ITER;
              cnt_r     <= {SHW{1'b1}};
              acc_r     <= {(WIDTH+1){1'b0}};
              q_r       <= a_mag_s;
              m_r       <= b_mag_s;
              is_div_r  <= is_div_op_s;
              neg_q_r   <= a_neg_s ^ b_neg_s;
              neg_rem_r <= a_neg_s;
            end else begin
              result_r <= sc_res_s;
              valid_r  <= 1'b1;
              zero_r   <= sc_zero_s;
              neg_r    <= sc_neg_s;
              ovf_r    <= sc_ovf_s;
            end
          end
        end
        S_ITER: begin
          acc_r <= acc_nx_s;
          q_r   <= q_nx_s;
          if (cnt_r == {SHW{1'b0}}) begin
            state_r <= S_SIGN;
          end else begin
            cnt_r <= cnt_r - {{(SHW-1){1'b0}}, 1'b1};
          end
        end
        S_SIGN: begin
          hi_r     <= hi_nx_s;
          lo_r     <= lo_nx_s;
          result_r <= lo_nx_s;
          valid_r  <= 1'b1;
          state_r  <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign o_ready       = (state_r == S_IDLE);
  assign o_valid       = valid_r;
  assign o_result      = result_r;
  assign o_zero        = zero_r;
  assign o_neg         = neg_r;
  assign o_overflow    = ovf_r;
  assign o_div_by_zero = dbz_r;
  assign o_hi          = hi_r;
  assign o_lo          = lo_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed table, multi-cycle corner sequences and
// random operations compared against an arithmetic reference model with its own HI/LO.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [4:0]  i_opcode = 5'd0;
  logic [31:0] i_a = 32'd0;
  logic [31:0] i_b = 32'd0;
  logic        o_ready, o_valid, o_zero, o_neg, o_overflow, o_div_by_zero;
  logic [31:0] o_result, o_hi, o_lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  alu_muldiv #(.WIDTH(32), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_opcode(i_opcode), .i_a(i_a), .i_b(i_b),
    .o_ready(o_ready), .o_valid(o_valid), .o_result(o_result), .o_zero(o_zero), .o_neg(o_neg),
    .o_overflow(o_overflow), .o_div_by_zero(o_div_by_zero), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic; flags packed as {zero,neg,ovf,dbz}
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [3:0] flags, output int lat);
    longint sa, sb, s, q, r;
    logic [63:0] ua, ub, up;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = a[4:0];
    res = 32'd0;
    flags = 4'b0000;
    lat = 1;
    case (op)
      5'd0: res = b << sh;
      5'd1: res = b >> sh;
      5'd2: res = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      5'd3: begin
        s = sa + sb;
        res = a + b;
        flags[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd4: begin
        s = sa - sb;
        res = a - b;
        flags[3] = (a == b);
        flags[2] = res[31];
        flags[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd5: res = a & b;
      5'd6: res = a | b;
      5'd7: res = a ^ b;
      5'd8: res = ~(a | b);
      5'd9: res = (sa < sb) ? 32'd1 : 32'd0;
      5'd10: res = (ua < ub) ? 32'd1 : 32'd0;
      5'd11: begin
        s = sa * sb;
        m_hi = s[63:32];
        m_lo = s[31:0];
        res = m_lo;
        lat = 34;
      end
      5'd12: begin
        up = ua * ub;
        m_hi = up[63:32];
        m_lo = up[31:0];
        res = m_lo;
        lat = 34;
      end
      5'd13, 5'd14: begin
        if (b == 32'd0) begin
          flags[0] = 1'b1;
        end else begin
          if (op == 5'd13) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
          end else begin
            m_lo = a / b;
            m_hi = a % b;
          end
          res = m_lo;
          lat = 34;
        end
      end
      5'd15: res = m_hi;
      5'd16: res = m_lo;
      default: res = 32'd0;
    endcase
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    logic [31:0] eres;
    logic [3:0] eflags;
    int elat;
    int lat;
    model(op, a, b, eres, eflags, elat);
    @(negedge clk);
    i_valid = 1'b1; i_opcode = op; i_a = a; i_b = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    if (elat > 1) chk({nm, " ready_low"}, {31'd0, o_ready}, 32'd0);
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, elat);
    chk({nm, " result"}, o_result, eres);
    chk({nm, " flags"}, {28'd0, o_zero, o_neg, o_overflow, o_div_by_zero}, {28'd0, eflags});
    chk({nm, " hi"}, o_hi, m_hi);
    chk({nm, " lo"}, o_lo, m_lo);
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    int unsigned r;
    logic [4:0] op;
    logic [31:0] a, b;

    vecs[0] = '{5'd3,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0010};
    vecs[1] = '{5'd4,  32'd5,         32'd5,         32'd0,         4'b1000};
    vecs[2] = '{5'd2,  32'd4,         32'hF000_0000, 32'hFF00_0000, 4'b0000};
    vecs[3] = '{5'd0,  32'd31,        32'd3,         32'h8000_0000, 4'b0000};
    vecs[4] = '{5'd1,  32'd4,         32'hF000_0000, 32'h0F00_0000, 4'b0000};
    vecs[5] = '{5'd4,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0010};
    vecs[6] = '{5'd4,  32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0100};
    vecs[7] = '{5'd9,  32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0000};
    vecs[8] = '{5'd10, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0000};
    vecs[9] = '{5'd8,  32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F, 4'b0000};

    #12;
    chk("reset ready", {31'd0, o_ready}, 32'd1);
    chk("reset valid", {31'd0, o_valid}, 32'd0);
    chk("reset result", o_result, 32'd0);
    chk("reset hi", o_hi, 32'd0);
    chk("reset lo", o_lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table with independently worked expected values
    foreach (vecs[i]) begin
      @(negedge clk);
      i_valid = 1'b1; i_opcode = vecs[i].op; i_a = vecs[i].a; i_b = vecs[i].b;
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk($sformatf("vec%0d valid", i), {31'd0, o_valid}, 32'd1);
      chk($sformatf("vec%0d result", i), o_result, vecs[i].res);
      chk($sformatf("vec%0d flags", i), {28'd0, o_zero, o_neg, o_overflow, o_div_by_zero},
          {28'd0, vecs[i].flags});
      @(posedge clk); #1;
      chk($sformatf("vec%0d pulse", i), {31'd0, o_valid, o_overflow, o_zero}, 32'd0);
    end

    do_op(5'd11, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
    chk("mult hi const", o_hi, 32'hFFFF_FFFF);
    chk("mult lo const", o_lo, 32'hFFFF_FFEB);
    do_op(5'd15, 32'd0, 32'd0, "mfhi");
    chk("mfhi const", o_result, 32'hFFFF_FFFF);
    do_op(5'd13, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
    chk("div lo const", o_lo, 32'hFFFF_FFFD);
    chk("div hi const", o_hi, 32'hFFFF_FFFF);
    do_op(5'd14, 32'd7, 32'd0, "divu_by0");
    chk("divu0 hi kept", o_hi, 32'hFFFF_FFFF);
    do_op(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    chk("minm1 lo const", o_lo, 32'h8000_0000);
    chk("minm1 hi const", o_hi, 32'd0);

    // Back-to-back: i_valid held through a MULTU, next op taken on completion
    @(negedge clk);
    i_valid = 1'b1; i_opcode = 5'd12; i_a = 32'hFFFF_FFFF; i_b = 32'd2;
    @(posedge clk); #1;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b latency", lat, 34);
    chk("b2b hi", o_hi, 32'd1);
    chk("b2b lo", o_lo, 32'hFFFF_FFFE);
    chk("b2b ready", {31'd0, o_ready}, 32'd1);
    i_opcode = 5'd16;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("b2b mflo valid", {31'd0, o_valid}, 32'd1);
    chk("b2b mflo result", o_result, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    chk("b2b no extra", {31'd0, o_valid}, 32'd0);
    m_hi = 32'd1;
    m_lo = 32'hFFFF_FFFE;

    // Random operations against the reference model
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      op = 5'($urandom_range(0, 20));
      a = $urandom;
      b = $urandom;
      if (r[1:0] == 2'd0) b = 32'($urandom_range(0, 3));
      if (r[3:2] == 2'd0) a = r[4] ? 32'h8000_0000 : 32'hFFFF_FFFF;
      if (r[6:5] == 2'd0) b = r[7] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      do_op(op, a, b, $sformatf("rand%0d op%0d", n, op));
    end

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    i_valid = 1'b1; i_opcode = 5'd13; i_a = 32'd1000; i_b = 32'd7;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst ready", {31'd0, o_ready}, 32'd1);
    chk("rst valid", {31'd0, o_valid}, 32'd0);
    chk("rst hi", o_hi, 32'd0);
    chk("rst lo", o_lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    do_op(5'd16, 32'd0, 32'd0, "post_rst_mflo");
    do_op(5'd12, 32'h1234_5678, 32'h0000_1000, "post_rst_multu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
